masked_and_pipe: RTL and testbench

MASKED_AND_PIPE -- requirements
Module: masked_and_pipe

---
 rtl/masking_pkg.sv | 20 ++
 rtl/masked_and_pipe_lane.sv | 74 +++++++
 rtl/masked_and_pipe.sv | 80 ++++++++
 tb/tb_masked_and_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masking_pkg.sv
// Shared constants and index helpers for the masked AND pipeline.
package masking_pkg;

   localparam int unsigned SHARES_MIN = 2;
   localparam int unsigned SHARES_MAX = 4;
   localparam int unsigned WIDTH_MIN  = 1;
   localparam int unsigned WIDTH_MAX  = 64;

   // Fresh random bits per lane per operation: one per unordered share pair.
   function automatic int unsigned nr_of(input int unsigned shares);
      return (shares * (shares - 1)) / 2;
   endfunction

   // Lexicographic index of pair (i,j), i<j, among all pairs of `shares` shares.
   function automatic int unsigned pidx(input int unsigned i, input int unsigned j,
                                        input int unsigned shares);
      return (i * shares) - ((i * (i + 1)) / 2) + (j - i - 1);
   endfunction

endpackage

// File: rtl/masked_and_pipe_lane.sv
// One bit-lane of the masked AND: all shares, stage-1 partial products and stage-2 compression.
module masked_and_pipe_lane
   import masking_pkg::*;
#(
   parameter int unsigned SHARES = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ld1,
   input  logic                        ld2,
   input  logic [SHARES-1:0]           a,
   input  logic [SHARES-1:0]           b,
   input  logic [nr_of(SHARES)-1:0]    rnd,
   output logic [SHARES-1:0]           f
);

   localparam int unsigned NR = nr_of(SHARES);

   logic [SHARES-1:0] inner_d, inner_q;
   logic [NR-1:0]     xij_d, xij_q;
   logic [NR-1:0]     xji_d, xji_q;
   logic [SHARES-1:0] f_d, f_q;

   for (genvar i = 0; i < SHARES; i++) begin : g_inner
      assign inner_d[i] = a[i] & b[i];
   end

   // Cross products are refreshed before they reach a register, so no unmasked value is ever stored.
   for (genvar i = 0; i < SHARES; i++) begin : g_row
      for (genvar j = i + 1; j < SHARES; j++) begin : g_pair
         localparam int unsigned P = pidx(i, j, SHARES);
         assign xij_d[P] = (a[i] & b[j]) ^ rnd[P];
         assign xji_d[P] = (a[j] & b[i]) ^ rnd[P];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inner_q <= '0;
         xij_q   <= '0;
         xji_q   <= '0;
      end else if (ld1) begin
         inner_q <= inner_d;
         xij_q   <= xij_d;
         xji_q   <= xji_d;
      end
   end

   // Domain i collects its inner term plus every term whose first operand is a_i.
   for (genvar i = 0; i < SHARES; i++) begin : g_dom
      logic [SHARES-1:0] own;
      for (genvar j = 0; j < SHARES; j++) begin : g_term
         if (j == i) begin : g_diag
            assign own[j] = inner_q[i];
         end else if (j > i) begin : g_hi
            assign own[j] = xij_q[pidx(i, j, SHARES)];
         end else begin : g_lo
            assign own[j] = xji_q[pidx(j, i, SHARES)];
         end
      end
      assign f_d[i] = ^own;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q <= '0;
      end else if (ld2) begin
         f_q <= f_d;
      end
   end

   assign f = f_q;

endmodule

// File: rtl/masked_and_pipe.sv
// Two-stage domain-oriented masked AND over WIDTH lanes with a shared valid/ready controller.
module masked_and_pipe
   import masking_pkg::*;
#(
   parameter int unsigned SHARES = 3,
   parameter int unsigned WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [SHARES*WIDTH-1:0]           a,
   input  logic [SHARES*WIDTH-1:0]           b,
   input  logic [nr_of(SHARES)*WIDTH-1:0]    rnd,
   input  logic                              rnd_valid,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SHARES*WIDTH-1:0]           f,
   output logic                              busy
);

   localparam int unsigned NR = nr_of(SHARES);

   if ((SHARES < SHARES_MIN) || (SHARES > SHARES_MAX)) begin : g_bad_shares
      $error("masked_and_pipe: SHARES=%0d outside %0d..%0d", SHARES, SHARES_MIN, SHARES_MAX);
   end
   if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
      $error("masked_and_pipe: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
   end

   logic s1_valid, s2_valid;
   logic s2_adv, accept, ld2;

   // Stage 2 drains into the consumer; stage 1 moves whenever stage 2 can take it.
   assign s2_adv   = !s2_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign accept   = in_valid && rnd_valid && in_ready;
   assign ld2      = s1_valid && s2_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (in_ready) s1_valid <= accept;
         if (s2_adv)   s2_valid <= s1_valid;
      end
   end

   assign out_valid = s2_valid;
   assign busy      = s1_valid | s2_valid;

   for (genvar l = 0; l < WIDTH; l++) begin : g_lane
      logic [SHARES-1:0] la, lb, lf;
      logic [NR-1:0]     lr;

      for (genvar k = 0; k < SHARES; k++) begin : g_sh
         assign la[k]           = a[k*WIDTH + l];
         assign lb[k]           = b[k*WIDTH + l];
         assign f[k*WIDTH + l]  = lf[k];
      end
      for (genvar p = 0; p < NR; p++) begin : g_rnd
         assign lr[p] = rnd[p*WIDTH + l];
      end

      masked_and_pipe_lane #(
         .SHARES (SHARES)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .ld1 (accept),
         .ld2 (ld2),
         .a   (la),
         .b   (lb),
         .rnd (lr),
         .f   (lf)
      );
   end

endmodule

// File: tb/tb_masked_and_pipe.sv
// Scoreboard bench: three lock-stepped instances (SHARES=2,3,4) driven by shared stimulus.
module tb_masked_and_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid, rnd_valid, out_ready;
   logic [31:0] a_bus, b_bus;
   logic [47:0] rnd_bus;
   logic        rdy2, rdy3, rdy4;
   logic        ov2, ov3, ov4;
   logic        busy2, busy3, busy4;
   logic [15:0] f2;
   logic [23:0] f3;
   logic [31:0] f4;

   int checks;
   int errors;
   int cyc = 0;
   int npush;
   int npop;
   bit rand_phase;
   bit ops_done;

   typedef struct {
      logic [7:0]  um2, um3, um4;
      logic [15:0] sh2;
      bit          chk_sh;
      int          acc;
      bit          chk_lat;
   } exp_t;

   exp_t q[$];

   localparam logic [31:0] VA [4] = '{32'h00A1_5C3E, 32'h7711_0F0F, 32'h1234_5678, 32'hDEAD_BEEF};
   localparam logic [31:0] VB [4] = '{32'h00FF_33C7, 32'h0F0F_F0F0, 32'h8765_4321, 32'hCAFE_F00D};

   masked_and_pipe #(.SHARES(2), .WIDTH(8)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
      .a(a_bus[15:0]), .b(b_bus[15:0]), .rnd(rnd_bus[7:0]), .rnd_valid(rnd_valid),
      .out_valid(ov2), .out_ready(out_ready), .f(f2), .busy(busy2));

   masked_and_pipe #(.SHARES(3), .WIDTH(8)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
      .a(a_bus[23:0]), .b(b_bus[23:0]), .rnd(rnd_bus[23:0]), .rnd_valid(rnd_valid),
      .out_valid(ov3), .out_ready(out_ready), .f(f3), .busy(busy3));

   masked_and_pipe #(.SHARES(4), .WIDTH(8)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
      .a(a_bus), .b(b_bus), .rnd(rnd_bus), .rnd_valid(rnd_valid),
      .out_valid(ov4), .out_ready(out_ready), .f(f4), .busy(busy4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // XOR of the first n byte-wide shares.
   function automatic logic [7:0] um(input logic [31:0] v, input int n);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < n; k++) r = r ^ v[k*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_op(input logic [31:0] av, input logic [31:0] bv, input bit csh,
                          input logic [15:0] sh, input bit clat);
      exp_t e;
      e.um2     = um(av, 2) & um(bv, 2);
      e.um3     = um(av, 3) & um(bv, 3);
      e.um4     = um(av, 4) & um(bv, 4);
      e.sh2     = sh;
      e.chk_sh  = csh;
      e.acc     = cyc;
      e.chk_lat = clat;
      q.push_back(e);
      npush++;
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the op.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic [47:0] rv,
                        input bit rnd_rand, input bit csh, input logic [15:0] sh, input bit clat);
      bit done;
      done      = 1'b0;
      a_bus     = av;
      b_bus     = bv;
      rnd_bus   = rv;
      in_valid  = 1'b1;
      rnd_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         if (rnd_rand) begin
            rnd_valid = ($urandom_range(0, 2) != 0);
            rnd_bus   = {16'($urandom), $urandom};
         end
         @(negedge clk);
         if (in_valid && rnd_valid && rdy3) begin
            chk("ready_lockstep", 64'({rdy2, rdy4}), 64'({rdy3, rdy3}));
            push_op(av, bv, csh, sh, clat);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no accept in 200 cycles, expected accept");
      end
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (ov2 || ov3 || ov4))
            chk("valid_lockstep", 64'({ov2, ov4}), 64'({ov3, ov3}));
         if (!rst && ov3 && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got out_valid=1 f3=%0h, expected no output", f3);
            end else begin
               e = q.pop_front();
               npop++;
               chk("unmasked_s2", 64'(um({16'h0, f2}, 2)), 64'(e.um2));
               chk("unmasked_s3", 64'(um({8'h0, f3}, 3)), 64'(e.um3));
               chk("unmasked_s4", 64'(um(f4, 4)), 64'(e.um4));
               if (e.chk_sh)  chk("shares_s2", 64'(f2), 64'(e.sh2));
               if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'(2));
            end
         end
      end
   endtask

   task automatic ready_toggler();
      forever begin
         @(posedge clk);
         #1;
         if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   initial begin
      int n0;
      logic [15:0] f2h;
      logic [23:0] f3h;
      checks = 0; errors = 0; npush = 0; npop = 0;
      rand_phase = 1'b0; ops_done = 1'b0;
      rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
      a_bus = '0; b_bus = '0; rnd_bus = '0;

      fork
         monitor();
         ready_toggler();
         begin
            #500000;
            $display("FAIL watchdog: got no finish by 500us, expected finish");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'({ov2, ov3, ov4}), 64'(0));
      chk("rst_busy", 64'({busy2, busy3, busy4}), 64'(0));
      chk("rst_f", 64'({f3, f4}), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 64'({rdy2, rdy3, rdy4}), 64'(3'b111));
      chk("post_rst_idle", 64'({ov3, busy3}), 64'(0));

      // Two-share vector with zero and nonzero randomness; hand-computed shares
      do_op(32'h0000_663C, 32'h0000_FF0F, 48'h0, 1'b0, 1'b1, 16'h6030, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      do_op(32'h0000_663C, 32'h0000_FF0F, 48'h0000_0000_00A5, 1'b0, 1'b1, 16'hC595, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Randomness gap: nothing may be accepted until rnd_valid rises
      a_bus = 32'h0081_4217; b_bus = 32'h00F0_3C99;
      in_valid = 1'b1; rnd_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("gap_in_ready", 64'(rdy3), 64'(1));
         chk("gap_no_accept", 64'({busy2, busy3, busy4}), 64'(0));
         @(posedge clk);
         #1;
      end
      n0 = npop;
      do_op(32'h0081_4217, 32'h00F0_3C99, 48'h1234_5678_9ABC, 1'b0, 1'b0, 16'h0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("gap_single_result", 64'(npop - n0), 64'(1));
      chk("gap_idle_after", 64'(busy3), 64'(0));

      // Back-pressure: two ops fill the pipe, then stall with f held
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++)
               do_op(VA[i], VB[i], {16'($urandom), $urandom}, 1'b0, 1'b0, 16'h0, 1'b0);
            ops_done = 1'b1;
         end
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      f2h = f2;
      f3h = f3;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(rdy3), 64'(0));
         chk("stall_out_valid", 64'(ov3), 64'(1));
         chk("stall_hold_product", 64'(um({8'h0, f3}, 3)), 64'(um(VA[0], 3) & um(VB[0], 3)));
         chk("stall_f_stable", 64'({f2, f3}), 64'({f2h, f3h}));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      n0 = npop;
      repeat (4) @(negedge clk);
      #1;
      chk("drain_1_per_cycle", 64'(npop - n0), 64'(4));
      for (int t = 0; t < 50 && !ops_done; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_queue_empty", 64'(q.size()), 64'(0));

      // Reset while an op sits in stage 1: it must vanish
      do_op(32'h5A5A_A5A5, 32'hFFFF_FFFF, 48'hABCD_EF01_2345, 1'b0, 1'b0, 16'h0, 1'b0);
      rst = 1'b1;
      q.delete();
      #1;
      chk("midop_rst_f", 64'({f2, f3, f4}), 64'(0));
      chk("midop_rst_busy", 64'({busy2, busy3, busy4}), 64'(0));
      chk("midop_rst_out_valid", 64'({ov2, ov3, ov4}), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n0 = npop;
      repeat (5) @(posedge clk);
      #1;
      chk("midop_no_output", 64'(npop - n0), 64'(0));
      chk("midop_idle", 64'({busy3, ov3, rdy3}), 64'(3'b001));

      // Random operands, randomness gaps and consumer stalls
      npush = 0;
      npop  = 0;
      rand_phase = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         do_op($urandom, $urandom, 48'h0, 1'b1, 1'b0, 16'h0, 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_phase = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("final_queue_empty", 64'(q.size()), 64'(0));
      chk("outputs_equal_accepts", 64'(npop), 64'(npush));
      chk("final_idle", 64'({busy2, busy3, busy4}), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
